// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, writeback and scoreboard-issue signals of the register file
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rbusy;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;
    logic                sb_full;

    modport master (
        output ra, we, wa, wd, sb_set, sb_addr,
        input  rd, rbusy, sb_full
    );

    modport slave (
        input  ra, we, wa, wd, sb_set, sb_addr,
        output rd, rbusy, sb_full
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write bypass and per-register pending-write scoreboard
module regfile_sb #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NRD     = 2,
    parameter int CNTW    = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    regfile_sb_if.slave     bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [CNTW-1:0] CMAX = '1;

    logic [XLEN-1:0]     rf_q  [NREGS];
    logic [XLEN-1:0]     rf_d  [NREGS];
    logic [CNTW-1:0]     cnt_q [NREGS];
    logic [CNTW-1:0]     cnt_d [NREGS];
    logic                set_ok;
    logic                wr_ok;
    logic                full;
    logic                inc;
    logic                dec;
    logic [NRD*XLEN-1:0] rd_v;
    logic [NRD-1:0]      busy_v;

    // Qualify issue and writeback: register 0 is inert when hardwired to zero
    always_comb begin
        set_ok = bus.sb_set && !(ZERO_R0 != 0 && bus.sb_addr == '0);
        full   = set_ok && cnt_q[bus.sb_addr] == CMAX;
        inc    = set_ok && !full;
        wr_ok  = bus.we && !(ZERO_R0 != 0 && bus.wa == '0);
        dec    = wr_ok && cnt_q[bus.wa] != '0;
    end

    // Next register contents and counts; inc and dec on one register cancel
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            rf_d[r]  = rf_q[r];
            cnt_d[r] = cnt_q[r] + CNTW'(inc && bus.sb_addr == AW'(r))
                                - CNTW'(dec && bus.wa == AW'(r));
        end
        if (wr_ok) rf_d[bus.wa] = bus.wd;
    end

    // Read ports: busy follows the post-edge count so a bypassed final write reads not-busy
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          v;
        assign a = bus.ra[i*AW +: AW];
        assign v = !(ZERO_R0 != 0 && a == '0);
        assign rd_v[i*XLEN +: XLEN] = !v ? '0 : (wr_ok && bus.wa == a) ? bus.wd : rf_q[a];
        assign busy_v[i] = v && cnt_d[a] != '0;
    end

    assign bus.rd      = rd_v;
    assign bus.rbusy   = busy_v;
    assign bus.sb_full = full;

    // State update with asynchronous clear of all registers and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                rf_q[r]  <= '0;
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                rf_q[r]  <= rf_d[r];
                cnt_q[r] <= cnt_d[r];
            end
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of read/bypass, scoreboard counting, saturation and async clear
module tb_regfile_sb;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .CNTW(2), .ZERO_R0(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.we = 1'b0;
        bus.sb_set = 1'b0;
    endtask

    task automatic setra(input logic [4:0] a0, input logic [4:0] a1);
        bus.ra = {a1, a0};
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.we = 1'b1;
        bus.wa = a;
        bus.wd = d;
    endtask

    task automatic iss(input logic [4:0] a);
        bus.sb_set = 1'b1;
        bus.sb_addr = a;
    endtask

    initial begin
        bus.ra = '0;
        bus.we = 1'b0;
        bus.wa = '0;
        bus.wd = '0;
        bus.sb_set = 1'b0;
        bus.sb_addr = '0;
        #3;
        for (int r = 0; r < 32; r++) begin
            setra(5'(r), 5'(31 - r));
            #1;
            chk($sformatf("rst_rd_r%0d", r), bus.rd, 64'h0);
            chk($sformatf("rst_busy_r%0d", r), bus.rbusy, 64'h0);
        end
        cyc();
        reset_n = 1'b1;
        // r0 hardwired to zero, including bypass
        wr(0, 32'hDEADBEEF);
        setra(0, 0);
        #1 chk("r0_bypass", bus.rd, 64'h0);
        cyc();
        idle();
        #1 chk("r0_read", bus.rd, 64'h0);
        // write then read, then same-cycle bypass
        wr(5, 32'h12345678);
        cyc();
        idle();
        setra(5, 0);
        #1 chk("r5_read", bus.rd[31:0], 64'h12345678);
        wr(5, 32'hCAFEF00D);
        setra(5, 5);
        #1 chk("r5_bypass_p1", bus.rd[63:32], 64'hCAFEF00D);
        chk("r5_bypass_p0", bus.rd[31:0], 64'hCAFEF00D);
        cyc();
        idle();
        #1 chk("r5_after", bus.rd[63:32], 64'hCAFEF00D);
        // scoreboard basic on r7
        iss(7);
        setra(7, 0);
        #1 chk("r7_set_busy", bus.rbusy, 64'h1);
        chk("r7_set_full", bus.sb_full, 64'h0);
        cyc();
        idle();
        #1 chk("r7_busy", bus.rbusy, 64'h1);
        wr(7, 32'h77);
        #1 chk("r7_wb_busy", bus.rbusy, 64'h0);
        chk("r7_wb_rd", bus.rd[31:0], 64'h77);
        cyc();
        idle();
        #1 chk("r7_after_busy", bus.rbusy, 64'h0);
        chk("r7_after_rd", bus.rd[31:0], 64'h77);
        // issue to r0 is ignored
        iss(0);
        setra(0, 0);
        #1 chk("r0_set_full", bus.sb_full, 64'h0);
        chk("r0_set_busy", bus.rbusy, 64'h0);
        cyc();
        idle();
        #1 chk("r0_set_after", bus.rbusy, 64'h0);
        // saturation on r3
        setra(3, 0);
        for (int k = 0; k < 3; k++) begin
            iss(3);
            #1 chk($sformatf("r3_set%0d_full", k), bus.sb_full, 64'h0);
            cyc();
        end
        iss(3);
        #1 chk("r3_set3_full", bus.sb_full, 64'h1);
        chk("r3_set3_busy", bus.rbusy, 64'h1);
        cyc();
        idle();
        wr(3, 32'h31);
        #1 chk("r3_wb0_busy", bus.rbusy, 64'h1);
        cyc();
        wr(3, 32'h32);
        #1 chk("r3_wb1_busy", bus.rbusy, 64'h1);
        cyc();
        wr(3, 32'h33);
        #1 chk("r3_wb2_busy", bus.rbusy, 64'h0);
        cyc();
        wr(3, 32'h34);
        #1 chk("r3_wb3_busy", bus.rbusy, 64'h0);
        cyc();
        idle();
        #1 chk("r3_final_rd", bus.rd[31:0], 64'h34);
        chk("r3_final_busy", bus.rbusy, 64'h0);
        // simultaneous inc and dec
        iss(9);
        cyc();
        idle();
        iss(9);
        wr(9, 32'h99);
        setra(9, 2);
        #1 chk("r9_same_busy", bus.rbusy, 64'h1);
        cyc();
        idle();
        #1 chk("r9_same_after", bus.rbusy, 64'h1);
        iss(2);
        wr(9, 32'h9A);
        #1 chk("r9_r2_busy", bus.rbusy, 64'h2);
        cyc();
        idle();
        #1 chk("r9_r2_after", bus.rbusy, 64'h2);
        chk("r9_rd", bus.rd[31:0], 64'h9A);
        // async clear mid-operation
        wr(4, 32'h55);
        iss(4);
        cyc();
        idle();
        iss(4);
        cyc();
        idle();
        setra(4, 2);
        #1 chk("r4_pre_rd", bus.rd[31:0], 64'h55);
        chk("r4_pre_busy", bus.rbusy, 64'h3);
        #1 reset_n = 1'b0;
        #1 chk("arst_rd", bus.rd, 64'h0);
        chk("arst_busy", bus.rbusy, 64'h0);
        #1 reset_n = 1'b1;
        cyc();
        #1 chk("post_rd", bus.rd, 64'h0);
        chk("post_busy", bus.rbusy, 64'h0);
        iss(4);
        cyc();
        idle();
        wr(4, 32'h66);
        #1 chk("post_r4_cnt0", bus.rbusy, 64'h0);
        cyc();
        idle();
        #1 chk("post_r4_rd", bus.rd[31:0], 64'h66);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
